// File: rtl/bb_scrambler.sv
// DVB-S2 baseband scrambler feeding the BCH encoder: PRBS 1+x^14+x^15 reloaded per frame,
// KBCH-bit framing, NPAR-cycle gap after each frame. Optional bypass port under BB_SCR_BYPASS_EN.
module bb_scrambler #(
   parameter int          KBCH      = 16008,
   parameter int          NPAR      = 192,
   parameter logic [14:0] PRBS_INIT = 15'b100101010000000
) (
   input  logic CLK,
   input  logic reset,
   input  logic start,
`ifdef BB_SCR_BYPASS_EN
   input  logic bypass,
`endif
   input  logic datain,
   input  logic din_valid,
   output logic din_ready,
   output logic dataout,
   output logic dataenable,
   output logic frame_start,
   output logic frame_end
);

   // The counter is shared between RUN and GAP, so NPAR must not exceed KBCH.
   localparam int CW = (KBCH > 1) ? $clog2(KBCH) : 1;
   localparam logic [CW-1:0] RUN_LAST = CW'(KBCH - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(NPAR - 1);

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [14:0]   prbs;
   logic          fb;
   logic          scr_en;
   logic          load;
   logic          accept;
   logic          last_bit;

   assign fb = prbs[1] ^ prbs[0];

   always_ff @(posedge CLK) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Handshake: a bit transfers on every cycle where din_valid && din_ready;
   // din_ready depends only on state (high exactly in RUN), never on din_valid.
   always_comb begin
      state_nx  = state;
      din_ready = 1'b0;
      load      = 1'b0;
      accept    = 1'b0;
      last_bit  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            din_ready = 1'b1;
            if (din_valid) begin
               accept = 1'b1;
               if (cnt == RUN_LAST) begin
                  last_bit = 1'b1;
                  state_nx = GAP;
               end
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset || load) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= last_bit ? '0 : cnt + CW'(1);
      end else if (state == GAP) begin
         cnt <= (cnt == GAP_LAST) ? '0 : cnt + CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (reset || load) prbs <= PRBS_INIT;
      else if (accept)   prbs <= {fb, prbs[14:1]};
   end

`ifdef BB_SCR_BYPASS_EN
   // Bypass is captured once per frame so a mid-frame toggle cannot split a block.
   always_ff @(posedge CLK) begin
      if (reset)     scr_en <= 1'b1;
      else if (load) scr_en <= ~bypass;
   end
`else
   assign scr_en = 1'b1;
`endif

   always_ff @(posedge CLK) begin
      if (reset) begin
         dataout     <= 1'b0;
         dataenable  <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
      end else begin
         dataenable  <= accept;
         frame_start <= accept && (cnt == '0);
         frame_end   <= last_bit;
         if (accept) dataout <= datain ^ (fb & scr_en);
      end
   end

endmodule

// File: tb/tb_bb_scrambler.sv
// Randomized bench for bb_scrambler: a keystream array built from the PRBS recurrence feeds an
// expected queue that a negedge monitor drains; a second KBCH=1 instance covers the single-bit frame.
module tb_bb_scrambler;
  localparam int          KB   = 1000;
  localparam int          NP   = 48;
  localparam logic [14:0] INIT = 15'b100101010000000;

  logic clk = 1'b0;
  logic reset, start, datain, din_valid;
  logic din_ready, dataout, dataenable, frame_start, frame_end;
`ifdef BB_SCR_BYPASS_EN
  logic bypass;
`endif
  logic start1, datain1, din_valid1;
  logic din_ready1, dataout1, dataenable1, frame_start1, frame_end1;

  logic [2:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  logic key [KB];
  logic seq [KB + 15];
  logic byp_cur = 1'b0;
  logic mon_on = 1'b0;
  logic lead_zero = 1'b0;
  logic last_out = 1'b0;
  logic [7:0] lead_byte = 8'h00;
  int lead_n = 8;

  bb_scrambler #(.KBCH(KB), .NPAR(NP), .PRBS_INIT(INIT)) dut (
    .CLK(clk), .reset(reset), .start(start),
`ifdef BB_SCR_BYPASS_EN
    .bypass(bypass),
`endif
    .datain(datain), .din_valid(din_valid), .din_ready(din_ready),
    .dataout(dataout), .dataenable(dataenable),
    .frame_start(frame_start), .frame_end(frame_end)
  );

  bb_scrambler #(.KBCH(1), .NPAR(1), .PRBS_INIT(INIT)) u_k1 (
    .CLK(clk), .reset(reset), .start(start1),
`ifdef BB_SCR_BYPASS_EN
    .bypass(1'b0),
`endif
    .datain(datain1), .din_valid(din_valid1), .din_ready(din_ready1),
    .dataout(dataout1), .dataenable(dataenable1),
    .frame_start(frame_start1), .frame_end(frame_end1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [2:0] e;
    if (mon_on) begin
      if (dataenable === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_de", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          popped++;
          check("dataout", dataout, e[2]);
          check("frame_start", frame_start, e[1]);
          check("frame_end", frame_end, e[0]);
          if (e[1]) lead_n = 0;
          if (lead_n < 8) begin
            lead_byte = {lead_byte[6:0], dataout};
            lead_n++;
            if (lead_n == 8 && lead_zero) check("lead_byte", lead_byte, 8'h03);
          end
        end
      end else begin
        check("idle_outs", {frame_start, frame_end, dataout}, {2'b00, last_out});
      end
    end
    last_out = dataout;
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; din_valid = 1'b0;
    @(posedge clk);
    mon_on = 1'b0;
    @(negedge clk);
    check("rst_outs", {dataout, dataenable, frame_start, frame_end, din_ready}, 5'b0);
    check("rst_q_empty", exp_q.size(), 0);
    reset = 1'b0;
    @(posedge clk);
    mon_on = 1'b1;
  endtask

  task automatic send_start();
    @(negedge clk);
    check("ready_idle", din_ready, 0);
`ifdef BB_SCR_BYPASS_EN
    bypass = byp_cur;
`endif
    start = 1'b1;
  endtask

  // dmode: 0 zeros, 1 random, 2 alternating 1010; vmode: 0 always, 1 toggle, 2 random
  task automatic run_frame(input int dmode, input int vmode, input int poke_at, input int abort_at);
    int i = 0;
    int guard = 0;
    logic d, v;
    logic tgl = 1'b1;
    lead_zero = (dmode == 0) && !byp_cur;
    while (i < KB && guard < 4 * KB) begin
      @(negedge clk);
      guard++;
      start = (i == poke_at);
      check("ready_run", din_ready, 1);
      if (i == abort_at) begin
        datain = 1'b1;
        do_reset();
        return;
      end
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? tgl : 1'($urandom_range(0, 1));
      tgl = ~tgl;
      d = (dmode == 0) ? 1'b0 : (dmode == 1) ? 1'($urandom_range(0, 1)) : (i % 2 == 0);
      din_valid = v;
      datain = d;
      if (v) begin
        exp_q.push_back({d ^ (key[i] & ~byp_cur), 1'(i == 0), 1'(i == KB - 1)});
        pushed++;
        i++;
      end
    end
    if (i < KB) check("frame_timeout", i, KB);
  endtask

  // After the last bit: NP cycles of GAP then at least one IDLE cycle, all with din_ready low.
  task automatic gap_phase(input logic hold, input int pulse_at);
    int low = 0;
    for (int k = 0; k <= NP; k++) begin
      @(negedge clk);
      din_valid = 1'b0;
      datain = 1'($urandom_range(0, 1));
      start = hold || (k == pulse_at);
      if (din_ready === 1'b0) low++;
    end
    check("gap_len", low, NP + 1);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
      check("idle_after_gap", din_ready, 0);
    end
  endtask

  initial begin
    logic [14:0] init_v;
    int bad;
    init_v = INIT;
    for (int i = 0; i < 15; i++) seq[i] = init_v[i];
    for (int n = 0; n < KB; n++) seq[n + 15] = seq[n] ^ seq[n + 1];
    for (int i = 0; i < KB; i++) key[i] = seq[i + 15];

    datain = 1'b0; din_valid = 1'b0; start = 1'b0;
    start1 = 1'b0; datain1 = 1'b0; din_valid1 = 1'b0;
`ifdef BB_SCR_BYPASS_EN
    bypass = 1'b0;
`endif
    do_reset();

    // zero payload, continuous valid; start held through the gap
    send_start();
    run_frame(0, 0, -1, -1);
    gap_phase(1'b1, -1);
    run_frame(0, 0, -1, -1);
    gap_phase(1'b0, 20);

    // random payload, valid toggling, start poked mid-frame
    send_start();
    run_frame(1, 1, 100, -1);
    gap_phase(1'b0, -1);

    // abort mid-frame, then a clean frame with random valid
    send_start();
    run_frame(1, 2, -1, 500);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      din_valid = 1'($urandom_range(0, 1));
      datain = 1'($urandom_range(0, 1));
      if (din_ready !== 1'b0) bad++;
    end
    check("abort_idle_ready", bad, 0);
    send_start();
    run_frame(0, 2, -1, -1);
    gap_phase(1'b0, -1);

`ifdef BB_SCR_BYPASS_EN
    byp_cur = 1'b1;
    send_start();
    run_frame(2, 0, -1, -1);
    gap_phase(1'b0, -1);
    byp_cur = 1'b0;
    send_start();
    run_frame(0, 0, -1, -1);
    gap_phase(1'b0, -1);
`endif

    // single-bit frame
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("k1_ready", din_ready1, 1);
    datain1 = 1'b1; din_valid1 = 1'b1;
    @(negedge clk);
    din_valid1 = 1'b0;
    check("k1_out", {dataout1, dataenable1, frame_start1, frame_end1}, {1'b1 ^ key[0], 3'b111});
    check("k1_ready_gap", din_ready1, 0);
    @(negedge clk);
    check("k1_ready_idle", din_ready1, 0);
    check("k1_de_off", {dataenable1, frame_start1, frame_end1}, 3'b000);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("k1_ready_again", din_ready1, 1);

    repeat (4) @(negedge clk);
    check("output_count", popped, pushed);
    check("q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
